// File: rtl/mips_mc_controller_if.sv
// Bundles the controller's instruction-register, handshake and strobe signals.
//   master : controller side (consumes op/funct/cond/mem_ready, drives strobes)
//   slave  : datapath/memory side
// Optional macro ILLEGAL_TRAP_EN adds the 'illegal' status signal.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       cond;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       retire;
    logic       mem_err;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        input  op, funct, cond, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
        output alucont, regwrite, regdst, memtoreg, retire, mem_err
`ifdef ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output op, funct, cond, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
        input  alucont, regwrite, regdst, memtoreg, retire, mem_err
`ifdef ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller with ALU decoder.
// Sequences FETCH -> DECODE -> execute states, waiting on mem_ready in the
// memory states, and drives every datapath strobe plus the ALU control.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mips_mc_controller_if.master (op, funct, cond, mem_ready in;
//              mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
//              alucont, regwrite, regdst, memtoreg, retire, mem_err out)
// Parameter MEM_WAIT_MAX (1..255): wait cycles before sticky mem_err is raised.
// Macro ILLEGAL_TRAP_EN: illegal op/funct parks the FSM in HALT and drives
// bus.illegal; otherwise illegal instructions retire as a NOP.
module mips_mc_controller #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_mc_controller_if.master bus
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_EQ  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
`ifdef ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    // Where an illegal instruction goes, and whether it counts as retired.
`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT   = S_HALT;
    localparam logic   ILL_RETIRE = 1'b0;
`else
    localparam state_t ILL_NEXT   = S_FETCH;
    localparam logic   ILL_RETIRE = 1'b1;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic       mem_req_c, memwrite_c, iord_c, irwrite_c, pcen_c;
    logic [1:0] pcsrc_c, alusrcb_c;
    logic       alusrca_c;
    logic [2:0] alucont_c, funct_alu_c;
    logic       funct_ok_c;
    logic       regwrite_c, regdst_c, memtoreg_c, retire_c;
    logic       mem_wait_c;

    // State, wait counter and sticky error register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // ALU decoder for R-type funct; sub has no ALU encoding and is illegal.
    always_comb begin
        funct_ok_c  = 1'b1;
        funct_alu_c = ALU_ADD;
        case (bus.funct)
            FN_ADD:  funct_alu_c = ALU_ADD;
            FN_AND:  funct_alu_c = ALU_AND;
            FN_OR:   funct_alu_c = ALU_OR;
            FN_SLT:  funct_alu_c = ALU_SLT;
            default: funct_ok_c  = 1'b0;
        endcase
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        iord_c     = 1'b0;
        irwrite_c  = 1'b0;
        pcen_c     = 1'b0;
        pcsrc_c    = 2'b00;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        alucont_c  = ALU_ADD;
        regwrite_c = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        retire_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb_c = 2'b01;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcen_c    = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d  = ILL_NEXT;
                        retire_c = ILL_RETIRE;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c  = 1'b1;
                memwrite_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca_c = 1'b1;
                if (funct_ok_c) begin
                    alucont_c = funct_alu_c;
                    state_d   = S_RTYPEWB;
                end else begin
                    state_d  = ILL_NEXT;
                    retire_c = ILL_RETIRE;
                end
            end
            S_RTYPEWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca_c = 1'b1;
                alucont_c = ALU_EQ;
                pcsrc_c   = 2'b01;
                pcen_c    = bus.cond;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc_c  = 2'b10;
                pcen_c   = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Wait counter: counts consecutive unanswered memory cycles, zero elsewhere.
    always_comb begin
        mem_wait_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        wait_cnt_d = '0;
        if (mem_wait_c && !bus.mem_ready) begin
            wait_cnt_d = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end
        mem_err_d = mem_err_q || (wait_cnt_d >= CNT_W'(MEM_WAIT_MAX));
    end

    // Strobes are forced low while reset is held so no write leaks out.
    assign bus.mem_req  = mem_req_c  & reset_n;
    assign bus.memwrite = memwrite_c & reset_n;
    assign bus.irwrite  = irwrite_c  & reset_n;
    assign bus.pcen     = pcen_c     & reset_n;
    assign bus.regwrite = regwrite_c & reset_n;
    assign bus.retire   = retire_c   & reset_n;
    assign bus.iord     = iord_c;
    assign bus.pcsrc    = pcsrc_c;
    assign bus.alusrca  = alusrca_c;
    assign bus.alusrcb  = alusrcb_c;
    assign bus.alucont  = alucont_c;
    assign bus.regdst   = regdst_c;
    assign bus.memtoreg = memtoreg_c;
    assign bus.mem_err  = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal  = (state_q == S_HALT);
`endif
endmodule

// File: tb/tb_mips_mc_controller.sv
// Testbench for mips_mc_controller: an instruction-level model expands each
// instruction into its expected per-cycle output trace, which is compared
// cycle by cycle against the DUT. Works with or without ILLEGAL_TRAP_EN.
module tb_mips_mc_controller;
    localparam int unsigned MAXW = 15;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mips_mc_controller_if bus ();

    mips_mc_controller #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucont;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       retire;
        logic       mem_err;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic  rdy;
        outs_t o;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_err;
    int   run;
    int   retire_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic outs_t idle();
        outs_t o = '0;
        o.alucont = 3'b010;
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.mem_req  = bus.mem_req;
        o.memwrite = bus.memwrite;
        o.iord     = bus.iord;
        o.irwrite  = bus.irwrite;
        o.pcen     = bus.pcen;
        o.pcsrc    = bus.pcsrc;
        o.alusrca  = bus.alusrca;
        o.alusrcb  = bus.alusrcb;
        o.alucont  = bus.alucont;
        o.regwrite = bus.regwrite;
        o.regdst   = bus.regdst;
        o.memtoreg = bus.memtoreg;
        o.retire   = bus.retire;
        o.mem_err  = bus.mem_err;
`ifdef ILLEGAL_TRAP_EN
        o.illegal  = bus.illegal;
`else
        o.illegal  = 1'b0;
`endif
        return o;
    endfunction

    // One expected cycle; tracks consecutive memory waits for the sticky error.
    task automatic push(input bit wst, input bit rdy, input outs_t o);
        rec_t r;
        o.mem_err = m_err;
        if (wst && !rdy) begin
            if (run < 255) run++;
            if (run >= int'(MAXW)) m_err = 1'b1;
        end else begin
            run = 0;
        end
        r.rdy = rdy;
        r.o   = o;
        q.push_back(r);
    endtask

    // Non-memory cycle: mem_ready is noise and must be ignored.
    task automatic push_x(input outs_t o);
        push(1'b0, 1'($urandom_range(1, 0)), o);
    endtask

    task automatic push_wait(input outs_t w, input outs_t done, input int k);
        for (int i = 0; i < k; i++) push(1'b1, 1'b0, w);
        push(1'b1, 1'b1, done);
    endtask

    task automatic push_illegal(input outs_t det, output bit halts);
`ifdef ILLEGAL_TRAP_EN
        outs_t h;
        push_x(det);
        h = idle();
        h.illegal = 1'b1;
        for (int i = 0; i < 3; i++) push_x(h);
        halts = 1'b1;
`else
        det.retire = 1'b1;
        push_x(det);
        halts = 1'b0;
`endif
    endtask

    // Instruction-level reference: expands one instruction into cycles.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] funct, input bit cond,
                               input int kf, input int km, output bit halts);
        outs_t w, o;
        bit    fok;
        logic [2:0] alu;
        halts = 1'b0;
        w = idle(); w.mem_req = 1'b1; w.alusrcb = 2'b01;
        o = w; o.irwrite = 1'b1; o.pcen = 1'b1;
        push_wait(w, o, kf);
        o = idle(); o.alusrcb = 2'b11;
        case (op)
            6'b100011, 6'b101011: begin
                push_x(o);
                o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                push_x(o);
                w = idle(); w.mem_req = 1'b1; w.iord = 1'b1;
                if (op == 6'b100011) begin
                    push_wait(w, w, km);
                    o = idle(); o.regwrite = 1'b1; o.memtoreg = 1'b1; o.retire = 1'b1;
                    push_x(o);
                end else begin
                    w.memwrite = 1'b1;
                    o = w; o.retire = 1'b1;
                    push_wait(w, o, km);
                end
            end
            6'b000000: begin
                push_x(o);
                fok = 1'b1;
                alu = 3'b010;
                case (funct)
                    6'b100000: alu = 3'b010;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   fok = 1'b0;
                endcase
                o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b00;
                if (fok) begin
                    o.alucont = alu;
                    push_x(o);
                    o = idle(); o.regwrite = 1'b1; o.regdst = 1'b1; o.retire = 1'b1;
                    push_x(o);
                end else begin
                    push_illegal(o, halts);
                end
            end
            6'b000100: begin
                push_x(o);
                o = idle(); o.alusrca = 1'b1; o.alucont = 3'b100; o.pcsrc = 2'b01;
                o.pcen = cond; o.retire = 1'b1;
                push_x(o);
            end
            6'b001000: begin
                push_x(o);
                o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                push_x(o);
                o = idle(); o.regwrite = 1'b1; o.retire = 1'b1;
                push_x(o);
            end
            6'b000010: begin
                push_x(o);
                o = idle(); o.pcsrc = 2'b10; o.pcen = 1'b1; o.retire = 1'b1;
                push_x(o);
            end
            default: push_illegal(o, halts);
        endcase
    endtask

    // Plays up to n queued cycles; entered and left at posedge+1.
    task automatic run_n(input string nm, input int n);
        rec_t  r;
        outs_t ob;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            bus.mem_ready = r.rdy;
            @(negedge clk);
            ob = observe();
            if (ob.retire) retire_seen++;
            check($sformatf("%s_c%0d", nm, i), 32'(ob), 32'(r.o));
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset away from the clock edge and checks strobes drop at once.
    task automatic do_reset(input string nm);
        outs_t ob;
        bus.mem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        ob = observe();
        check({nm, "_rst"}, 32'({ob.mem_req, ob.memwrite, ob.irwrite, ob.pcen, ob.regwrite,
                                  ob.retire, ob.mem_err, ob.illegal}), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_err = 1'b0;
        run = 0;
    endtask

    task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] funct,
                            input bit cond, input int kf, input int km);
        bit halts;
        bus.op = op;
        bus.funct = funct;
        bus.cond = cond;
        model_instr(op, funct, cond, kf, km, halts);
        run_n(nm, q.size());
        if (halts) do_reset({nm, "_halt"});
    endtask

    logic [5:0] fv [4];
    logic [5:0] op_r, fn_r;
    int kind;

    initial begin
        fv[0] = 6'b100000; fv[1] = 6'b100100; fv[2] = 6'b100101; fv[3] = 6'b101010;
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.op = '0;
        bus.funct = '0;
        bus.cond = 1'b0;
        m_err = 1'b0;
        run = 0;
        @(posedge clk);
        #1;
        do_reset("por");

        do_instr("add", 6'b000000, 6'b100000, 1'b0, 0, 0);
        retire_seen = 0;
        do_instr("lw_dly", 6'b100011, 6'b000000, 1'b0, 3, 3);
        check("lw_retire_count", 32'(retire_seen), 32'd1);
        do_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 0, 0);
        do_instr("beq_f", 6'b000100, 6'b000000, 1'b0, 0, 0);
        do_instr("sw", 6'b101011, 6'b000000, 1'b0, 1, 2);
        do_instr("addi", 6'b001000, 6'b000000, 1'b0, 0, 0);
        do_instr("slt", 6'b000000, 6'b101010, 1'b0, 0, 0);
        do_instr("sub", 6'b000000, 6'b100010, 1'b0, 0, 0);
        do_instr("badop", 6'b111111, 6'b000000, 1'b0, 0, 0);

        // Reset in the middle of a store's memory wait.
        bus.op = 6'b101011;
        bus.funct = '0;
        begin
            bit h;
            model_instr(6'b101011, 6'b000000, 1'b0, 0, 6, h);
        end
        run_n("rw", 4);
        q.delete();
        bus.mem_ready = 1'b0;
        #1;
        check("rw_memwrite_pre", 32'(bus.memwrite), 32'd1);
        do_reset("rw");
        do_instr("rw_after", 6'b000010, 6'b000000, 1'b0, 0, 0);

        // Wait-limit boundary: 14 waits stay clean, 15 set the sticky error.
        do_instr("w14", 6'b000010, 6'b000000, 1'b0, 14, 0);
        do_instr("w15", 6'b000010, 6'b000000, 1'b0, 15, 0);
        check("merr_sticky", 32'(bus.mem_err), 32'd1);
        do_instr("w15_next", 6'b001000, 6'b000000, 1'b0, 0, 0);
        do_reset("merr_clr");

        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(9, 0));
            fn_r = 6'($urandom);
            case (kind)
                0: op_r = 6'b100011;
                1: op_r = 6'b101011;
                2, 3: begin op_r = 6'b000000; fn_r = fv[$urandom_range(3, 0)]; end
                4: op_r = 6'b000000;
                5: op_r = 6'b000100;
                6: op_r = 6'b001000;
                7: op_r = 6'b000010;
                default: op_r = 6'($urandom);
            endcase
            do_instr($sformatf("r%0d", n), op_r, fn_r, 1'($urandom_range(1, 0)),
                     ($urandom_range(19, 0) == 0) ? int'($urandom_range(20, 10)) : int'($urandom_range(4, 0)),
                     int'($urandom_range(4, 0)));
            if ((n % 40) == 39) do_reset($sformatf("r%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
